// File: rtl/conv_host.sv
// Convolution host: image preload/readout memory, engine handshake FSM, layer result memories with write counters.
// Memory reads for the engine are combinational; host readout is one cycle. There is no backpressure: ld, cwr and rd_req are accepted or dropped in the cycle they are presented.
module conv_host #(
    parameter int DW          = 20,
    parameter int ARM_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [11:0]   ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    output logic          ready,
    input  logic          busy,
    input  logic [11:0]   iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [11:0]   caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [11:0]   caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    input  logic          rd_req,
    input  logic          rd_sel,
    input  logic [11:0]   rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic [12:0]   wr_cnt_l0,
    output logic [10:0]   wr_cnt_l1,
    output logic          err_timeout,
    output logic          err_csel,
    output logic          err_range
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    localparam int         TW      = $clog2(ARM_TIMEOUT) + 1;
    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    logic [DW-1:0] img [4096];
    logic [DW-1:0] l0  [4096];
    logic [DW-1:0] l1  [1024];

    state_t        state, state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          arm_entry;
    logic          wr_en, l0_we, l1_we, l1_in_range, csel_bad, range_bad;
    logic          rd_fire, rd_l1_in_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = ARM;
            ARM: begin
                if (busy) begin
                    state_nxt = RUN;
                end else if (tmo_cnt == TW'(ARM_TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    tmo_hit   = 1'b1;
                end
            end
            RUN:  if (!busy) state_nxt = DONE;
            DONE: if (start) state_nxt = ARM;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready     = (state == ARM);
    assign done      = (state == DONE);
    assign arm_entry = (state_nxt == ARM) && (state != ARM);

    // Counts edges spent in ARM; zero on the first ARM cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              tmo_cnt <= '0;
        else if (state != ARM)  tmo_cnt <= '0;
        else                    tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign wr_en       = (state == RUN) && cwr;
    assign l1_in_range = (caddr_wr[11:10] == 2'b00);
    assign l0_we       = wr_en && (csel == CSEL_L0);
    assign l1_we       = wr_en && (csel == CSEL_L1) && l1_in_range;
    assign range_bad   = wr_en && (csel == CSEL_L1) && !l1_in_range;
    assign csel_bad    = wr_en && (csel != CSEL_L0) && (csel != CSEL_L1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_l0   <= '0;
            wr_cnt_l1   <= '0;
            err_timeout <= 1'b0;
            err_csel    <= 1'b0;
            err_range   <= 1'b0;
        end else if (arm_entry) begin
            wr_cnt_l0   <= '0;
            wr_cnt_l1   <= '0;
            err_timeout <= 1'b0;
            err_csel    <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            if (l0_we && (wr_cnt_l0 != 13'd4096)) wr_cnt_l0 <= wr_cnt_l0 + 13'd1;
            if (l1_we && (wr_cnt_l1 != 11'd1024)) wr_cnt_l1 <= wr_cnt_l1 + 11'd1;
            if (tmo_hit)   err_timeout <= 1'b1;
            if (csel_bad)  err_csel    <= 1'b1;
            if (range_bad) err_range   <= 1'b1;
        end
    end

    // Memories are deliberately left out of reset so results survive an abort.
    always_ff @(posedge clk) begin
        if (ld_valid && ((state == IDLE) || (state == DONE))) img[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (l0_we) l0[caddr_wr] <= cdata_wr;
    end

    always_ff @(posedge clk) begin
        if (l1_we) l1[caddr_wr[9:0]] <= cdata_wr;
    end

    assign idata    = img[iaddr];
    // Same-address read during a write sees the old word; the write lands at the edge.
    assign cdata_rd = ((state == RUN) && crd && (csel == CSEL_L0)) ? l0[caddr_rd] : '0;

    assign rd_fire        = (state == DONE) && rd_req;
    assign rd_l1_in_range = (rd_addr[11:10] == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                if (!rd_sel)             rd_data <= l0[rd_addr];
                else if (rd_l1_in_range) rd_data <= l1[rd_addr[9:0]];
                else                     rd_data <= '0;
            end
        end
    end

endmodule

// File: doc/conv_host.md
CONV_HOST -- requirements
Module: conv_host

Interface
REQ-001 Parameter DW, default 20, pixel/data width in bits.
REQ-002 Parameter ARM_TIMEOUT, default 16, cycles to wait for busy after ready is raised.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ld_valid / ld_addr / ld_data  input  1/12/DW  image preload write into 4096-entry image memory.
REQ-006 start  input  1  one-cycle pulse requesting a convolution run.
REQ-007 ready  output  1  run request to the convolution engine.
REQ-008 busy  input  1  engine busy indication.
REQ-009 iaddr  input  12  image read address; idata  output  DW  image pixel.
REQ-010 cwr / caddr_wr / cdata_wr  input  1/12/DW  engine write strobe, address, data.
REQ-011 crd / caddr_rd  input  1/12  engine read strobe and address; cdata_rd  output  DW  read data.
REQ-012 csel  input  3  layer select: 3'b001 = L0 (4096 x DW), 3'b011 = L1 (1024 x DW).
REQ-013 rd_req / rd_sel / rd_addr  input  1/1/12  host readout request (rd_sel 0 = L0, 1 = L1).
REQ-014 rd_valid / rd_data  output  1/DW  host readout response.
REQ-015 done  output  1  run complete, results readable.
REQ-016 wr_cnt_l0 / wr_cnt_l1  output  13/11  accepted write counts per layer.
REQ-017 err_timeout / err_csel / err_range  output  1 each  sticky error flags.

Function
REQ-018 The FSM SHALL have states IDLE, ARM, RUN and DONE.
REQ-019 IDLE: ready=0; start -> ARM.
REQ-020 ARM: ready=1. The SHALL clear wr_cnt_l0, wr_cnt_l1 and all error flags on the cycle it enters ARM.
REQ-021 ARM: busy sampled 1 -> RUN, with ready=0 from the next cycle. ARM_TIMEOUT cycles without busy -> err_timeout=1 and return to IDLE.
REQ-022 RUN: busy sampled 0 -> DONE. start SHALL be ignored in RUN.
REQ-023 DONE: done=1. start -> ARM, and done=0 from the next cycle.
REQ-024 ld_valid SHALL write img[ld_addr] <= ld_data at the edge only in IDLE or DONE; it SHALL be ignored in ARM and RUN.
REQ-025 idata SHALL equal img[iaddr] combinationally in every state, with zero added latency.
REQ-026 RUN, cwr=1, csel=001: the block SHALL write L0[caddr_wr] <= cdata_wr at the edge and increment wr_cnt_l0, saturating at 4096.
REQ-027 RUN, cwr=1, csel=011, caddr_wr<1024: the block SHALL write L1[caddr_wr[9:0]] and increment wr_cnt_l1, saturating at 1024.
REQ-028 csel=011 with caddr_wr>=1024: the write SHALL be dropped and err_range set.
REQ-029 RUN, cwr=1, any other csel value: the write SHALL be dropped and err_csel set.
REQ-030 cdata_rd SHALL equal L0[caddr_rd] combinationally when crd=1 and csel=001, and 0 otherwise.
REQ-031 cwr and crd to the same L0 address in the same cycle: cdata_rd SHALL return the pre-write contents; the write commits at the edge.
REQ-032 cwr/crd outside RUN SHALL be ignored, with no write, no counter change and no error set.
REQ-033 Readout: in DONE, rd_req=1 SHALL produce rd_valid=1 on the next cycle with registered rd_data = (rd_sel ? L1[rd_addr[9:0]] : L0[rd_addr]).
REQ-034 Readout with rd_sel=1 and rd_addr>=1024 SHALL return rd_data=0.
REQ-035 rd_req outside DONE: rd_valid SHALL stay 0 and rd_data SHALL hold its value.
REQ-036 Back-to-back rd_req SHALL give one response per cycle, in order.
REQ-037 Error flags SHALL be sticky until the next ARM entry or reset.

Reset
REQ-038 reset SHALL force IDLE with ready=0, done=0, rd_valid=0, rd_data=0, both counters 0 and all error flags 0.
REQ-039 Memory contents SHALL NOT be cleared by reset.
REQ-040 reset asserted mid-RUN SHALL abort the run with no further writes; the host SHALL issue start again to rerun.

Verification
REQ-041 Preload img[65]=20'h00123, set iaddr=65 -> idata=20'h00123 in the same cycle.
REQ-042 start, busy rises 3 cycles later -> ready high for exactly 3 cycles, RUN entered, err_timeout=0.
REQ-043 start, busy held 0 -> err_timeout=1 after 16 cycles, FSM back in IDLE, ready=0.
REQ-044 RUN: write L0[4095]=20'h7FFFF and L1[1023]=20'h00042, then busy=0 -> done=1, wr_cnt_l0=1, wr_cnt_l1=1; rd_req with rd_sel=0/rd_addr=4095 -> next cycle rd_valid=1, rd_data=20'h7FFFF.
REQ-045 RUN: cwr with csel=011, caddr_wr=1024 -> err_range=1 and L1 unchanged; cwr with csel=010 -> err_csel=1.
REQ-046 RUN: same-cycle cwr and crd to L0[10] (old value 5, new value 9) -> cdata_rd=5 that cycle and 9 the following cycle.
